// File: rtl/sobel_axis_out.sv
// Output framing stage: tags the unframed Sobel pixel stream with sof/eol from
// line/row counters and drives the sink through a two-entry skid buffer.
module sobel_axis_out #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 24,
  localparam int HW   = $clog2(IMG_W),
  localparam int VW   = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_clr,
  input  logic [DW-1:0] data_m,
  input  logic          valid_m,
  output logic          ready_m,
  output logic [DW-1:0] data_s,
  output logic          valid_s,
  output logic          sof_s,
  output logic          eol_s,
  input  logic          ready_s,
  output logic          frame_done,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [1:0]    dbg_state_o
);

  // Beat tag layout: {last_of_frame, eol, sof, data}.
  localparam int TW = DW + 3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   out_q, out_d;
  logic [TW-1:0]   skid_q, skid_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic            frame_done_q, frame_done_d;

  logic            accept;
  logic            out_hs;
  logic            tag_sof, tag_eol, tag_last;
  logic [TW-1:0]   in_tag;

  // Handshake rule on both sides: a beat moves on a rising clk edge where
  // valid and ready are both high; valid never drops until that happens.
  assign accept   = valid_m && ready_q;
  assign out_hs   = valid_q && ready_s;
  assign tag_sof  = (hcnt_q == '0) && (vcnt_q == '0);
  assign tag_eol  = (hcnt_q == HW'(IMG_W - 1));
  assign tag_last = tag_eol && (vcnt_q == VW'(IMG_H - 1));
  assign in_tag   = {tag_last, tag_eol, tag_sof, data_m};

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    skid_d       = skid_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    frame_done_d = 1'b0;
    if (frame_clr) begin
      state_d = S_EMPTY;
      hcnt_d  = '0;
      vcnt_d  = '0;
    end else begin
      frame_done_d = out_hs && out_q[TW-1];
      if (accept) begin
        if (tag_eol) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == VW'(IMG_H - 1)) ? '0 : vcnt_q + VW'(1);
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_d   = in_tag;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && ready_s) begin
            out_d = in_tag;
          end else if (accept) begin
            skid_d  = in_tag;
            state_d = S_TWO;
          end else if (ready_s) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (ready_s) begin
            out_d   = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    valid_d = (state_d != S_EMPTY);
    ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      out_q        <= '0;
      skid_q       <= '0;
      valid_q      <= 1'b0;
      ready_q      <= 1'b1;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready_m     = ready_q;
  assign valid_s     = valid_q;
  assign data_s      = out_q[DW-1:0];
  assign sof_s       = out_q[DW];
  assign eol_s       = out_q[DW+1];
  assign frame_done  = frame_done_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign dbg_state_o = state_q;

endmodule
